// File: rtl/hls_obf_pkg.sv
// Shared constants for the key-locked MAC: one-hot FSM encodings and the
// bit positions of the functional key bits.
package hls_obf_pkg;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_LOAD = 4'b0010;
  localparam logic [3:0] ST_MAC  = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  localparam int KEY_START = 0;
  localparam int KEY_DONE  = 1;
  localparam int KEY_SUB   = 2;
  localparam int KEY_SAT   = 3;
  localparam int KEY_VLD   = 4;
  localparam int KEY_IDLE  = 5;

  localparam int WKEY_W = 6;

endpackage

// File: rtl/hls_obf_sat.sv
// Narrow a signed IN_W value to OUT_W bits, either clamping to the signed
// OUT_W range or keeping the low bits (two's complement wrap).
module hls_obf_sat #(
  parameter int IN_W  = 66,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_i,
  input  logic             sat_en_i,
  output logic [OUT_W-1:0] out_o
);

  localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] top_bits;
  logic                ovf;

  // Value fits only when every bit from the result sign bit upward agrees.
  assign top_bits = in_i[IN_W-1:OUT_W-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  // Clamp toward the sign of the wide value on overflow, else truncate.
  always_comb begin
    out_o = in_i[OUT_W-1:0];
    if (sat_en_i && ovf) out_o = in_i[IN_W-1] ? MIN_V : MAX_V;
  end

endmodule

// File: rtl/hls_macc_obf_param.sv
// Key-locked multiply-accumulate: seeds with c_in, then adds (or subtracts,
// when g_in exceeds THRESH) one a[k]*b[k] product per cycle, and emits a
// wrapped or saturated DATA_W result with HLS-style handshake flags.
module hls_macc_obf_param
  import hls_obf_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int N_TERMS = 4,
  parameter int THRESH  = 10,
  parameter int LOCK_W  = 3071
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        ap_ready,
  input  logic [N_TERMS*DATA_W-1:0]   a_in,
  input  logic [N_TERMS*DATA_W-1:0]   b_in,
  input  logic [DATA_W-1:0]           c_in,
  input  logic [DATA_W-1:0]           g_in,
  input  logic                        sat_en,
  output logic [DATA_W-1:0]           o_acc,
  output logic                        o_acc_vld,
  input  logic [LOCK_W-1:0]           locking_key
);

  localparam int KW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int AW = PW + $clog2(N_TERMS);
  localparam logic signed [DATA_W-1:0] THR = DATA_W'(THRESH);

  logic [WKEY_W-1:0] wkey;
  logic              unused_key;

  logic [3:0]                       state_q, state_d;
  logic [N_TERMS-1:0][DATA_W-1:0]   a_q, b_q;
  logic signed [AW-1:0]             acc_q, acc_d;
  logic [KW-1:0]                    k_q;
  logic                             sub_q, sat_q;
  logic [DATA_W-1:0]                o_acc_q, o_acc_d;

  logic                 start_c, sub_c, sat_c, last_k;
  logic signed [DATA_W-1:0] g_s, a_k, b_k;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext, c_ext;

  // Only the low key bits steer logic; the rest is decoy width.
  assign wkey       = locking_key[WKEY_W-1:0];
  assign unused_key = ^locking_key[LOCK_W-1:WKEY_W];

  assign start_c = ap_start ^ wkey[KEY_START];
  assign g_s     = g_in;
  assign sub_c   = (g_s > THR) ^ wkey[KEY_SUB];
  assign sat_c   = sat_q ^ wkey[KEY_SAT];
  assign last_k  = (k_q == KW'(N_TERMS - 1));

  // Signed product kept at full 2*DATA_W, then sign-extended into the
  // accumulator headroom so N_TERMS terms can never overflow it.
  assign a_k      = a_q[k_q];
  assign b_k      = b_q[k_q];
  assign prod     = a_k * b_k;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign c_ext    = {{(AW-DATA_W){c_in[DATA_W-1]}}, c_in};
  assign acc_d    = sub_q ? (acc_q - prod_ext) : (acc_q + prod_ext);

  hls_obf_sat #(.IN_W(AW), .OUT_W(DATA_W)) u_sat (
    .in_i     (acc_d),
    .sat_en_i (sat_c),
    .out_o    (o_acc_d)
  );

  // Next-state logic: IDLE -> LOAD -> MAC x N_TERMS -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_c) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_MAC;
      ST_MAC:  if (last_k) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; operands are snapshotted in LOAD so later
  // input changes cannot disturb the running operation.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      o_acc_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_LOAD: begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= c_ext;
          k_q   <= '0;
          sub_q <= sub_c;
          sat_q <= sat_en;
        end
        ST_MAC: begin
          acc_q <= acc_d;
          k_q   <= last_k ? '0 : k_q + KW'(1);
          if (last_k) o_acc_q <= o_acc_d;
        end
        default: ;
      endcase
    end
  end

  assign ap_done   = (state_q == ST_DONE) ^ wkey[KEY_DONE];
  assign ap_ready  = (state_q == ST_DONE);
  assign o_acc_vld = (state_q == ST_DONE) ^ wkey[KEY_VLD];
  assign ap_idle   = ((state_q == ST_IDLE) & ~ap_start) ^ wkey[KEY_IDLE];
  assign o_acc     = o_acc_q;

endmodule

// File: tb/tb_hls_macc_obf_param.sv
// Directed bench for hls_macc_obf_param with hand-computed expectations.
module tb_hls_macc_obf_param;

  localparam int DW = 32;
  localparam int NT = 4;
  localparam int LW = 3071;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, done, idle, ready, sat, vld;
  logic [NT*DW-1:0] a, b;
  logic [DW-1:0] c, g, acc;
  logic [LW-1:0] key;

  int total = 0;
  int bad   = 0;

  hls_macc_obf_param #(.DATA_W(DW), .N_TERMS(NT), .THRESH(10), .LOCK_W(LW)) dut (
    .ap_clk      (clk),
    .ap_rst_n    (rst_n),
    .ap_start    (start),
    .ap_done     (done),
    .ap_idle     (idle),
    .ap_ready    (ready),
    .a_in        (a),
    .b_in        (b),
    .c_in        (c),
    .g_in        (g),
    .sat_en      (sat),
    .o_acc       (acc),
    .o_acc_vld   (vld),
    .locking_key (key)
  );

  function automatic logic [NT*DW-1:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, scramble inputs mid-MAC, wait for ap_done.
  task automatic do_op(input logic [NT*DW-1:0] av, input logic [NT*DW-1:0] bv,
                       input logic [DW-1:0] cv, input logic [DW-1:0] gv, input logic sv,
                       output logic [DW-1:0] res, output int lat);
    int vbad;
    a = av; b = bv; c = cv; g = gv; sat = sv; start = 1'b1;
    lat = 0; vbad = 0;
    tick(); start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (vld !== (done ^ key[4])) vbad++;
      tick(); lat++;
      if (lat == 3) begin a = ~av; b = ~bv; c = ~cv; g = ~gv; sat = ~sv; end
    end
    res = acc;
    chk("vld_track", 64'(vbad), 64'd0);
    chk("vld_at_done", {63'd0, vld}, {63'd0, ~key[4]});
    chk("ready_at_done", {63'd0, ready}, 64'd1);
  endtask

  logic [DW-1:0] r;
  int lt;
  int seen, cyc, nd;
  int tdone[3];
  logic [DW-1:0] rres[3];

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = '0; g = '0; sat = 1'b0; key = '0;
    tick(); tick();
    chk("rst_idle", {63'd0, idle}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_vld", {63'd0, vld}, 64'd0);
    chk("rst_acc", 64'(acc), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic add path and latency.
    do_op(pk(1,2,3,4), pk(5,6,7,8), 32'd10, 32'd0, 1'b0, r, lt);
    chk("add_res", 64'(r), 64'd80);
    chk("add_lat", 64'(lt), 64'd6);
    tick();
    chk("idle_after", {63'd0, idle}, 64'd1);
    chk("vld_after", {63'd0, vld}, 64'd0);
    chk("acc_held", 64'(acc), 64'd80);

    do_op(pk(1,2,3,4), pk(5,6,7,8), 32'd10, 32'd11, 1'b0, r, lt);
    chk("sub_res", 64'(r), 64'(32'hFFFF_FFC4));
    tick();
    do_op(pk(1,2,3,4), pk(5,6,7,8), 32'd10, 32'd10, 1'b0, r, lt);
    chk("thr_eq_res", 64'(r), 64'd80);
    tick();

    // Reset while in MAC at k=2.
    a = pk(1,2,3,4); b = pk(5,6,7,8); c = 32'd10; g = 32'd0; sat = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_idle", {63'd0, idle}, 64'd1);
    chk("mid_rst_acc", 64'(acc), 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (vld !== 1'b0 || done !== 1'b0) seen++;
    end
    chk("abandon", 64'(seen), 64'd0);
    do_op(pk(1,2,3,4), pk(5,6,7,8), 32'd10, 32'd0, 1'b0, r, lt);
    chk("post_rst_res", 64'(r), 64'd80);
    chk("post_rst_lat", 64'(lt), 64'd6);
    tick();

    // Saturation vs wrap, positive and negative overflow.
    do_op(pk(32'h4000_0000, 32'h4000_0000, 0, 0), pk(2,2,0,0), 32'd0, 32'd0, 1'b1, r, lt);
    chk("sat_pos", 64'(r), 64'(32'h7FFF_FFFF));
    tick();
    do_op(pk(32'h4000_0000, 32'h4000_0000, 0, 0), pk(2,2,0,0), 32'd0, 32'd0, 1'b0, r, lt);
    chk("wrap_pos", 64'(r), 64'd0);
    tick();
    do_op(pk(32'h8000_0000, 32'h8000_0000, 0, 0), pk(1,1,0,0), 32'd0, 32'd0, 1'b1, r, lt);
    chk("sat_neg", 64'(r), 64'(32'h8000_0000));
    tick();
    do_op(pk(32'h8000_0000, 32'h8000_0000, 0, 0), pk(1,1,0,0), 32'd0, 32'd0, 1'b0, r, lt);
    chk("wrap_neg", 64'(r), 64'd0);
    tick();

    // Wrong key bit 2 flips the add/subtract decision.
    key[2] = 1'b1;
    do_op(pk(1,2,3,4), pk(5,6,7,8), 32'd10, 32'd0, 1'b0, r, lt);
    chk("key2_res", 64'(r), 64'(32'hFFFF_FFC4));
    key = '0;
    tick();

    // Wrong key bit 4 inverts the valid strobe.
    key[4] = 1'b1;
    #1;
    chk("key4_idle_vld", {63'd0, vld}, 64'd1);
    do_op(pk(1,2,3,4), pk(5,6,7,8), 32'd10, 32'd0, 1'b0, r, lt);
    chk("key4_res", 64'(r), 64'd80);
    key = '0;
    tick();

    // Back-to-back with ap_start held high.
    a = pk(1,2,3,4); b = pk(5,6,7,8); c = 32'd10; g = 32'd0; sat = 1'b0; start = 1'b1;
    #1;
    chk("idle_start_hi", {63'd0, idle}, 64'd0);
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 60) begin
      tick(); cyc++;
      if (done === 1'b1) begin
        rres[nd] = acc; tdone[nd] = cyc; nd++;
        if (nd == 1) g = 32'd11;
        else if (nd == 2) begin a = pk(-1,-1,-1,-1); b = pk(1,2,3,4); c = 32'd0; g = 32'd0; end
        else start = 1'b0;
      end
    end
    chk("b2b_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      chk("b2b_t0", 64'(tdone[0]), 64'd6);
      chk("b2b_t1", 64'(tdone[1]), 64'd13);
      chk("b2b_t2", 64'(tdone[2]), 64'd20);
      chk("b2b_r0", 64'(rres[0]), 64'd80);
      chk("b2b_r1", 64'(rres[1]), 64'(32'hFFFF_FFC4));
      chk("b2b_r2", 64'(rres[2]), 64'(32'hFFFF_FFF6));
    end
    tick(); tick();
    chk("b2b_idle_end", {63'd0, idle}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hls_macc_obf_param.md
HLS_MACC_OBF_PARAM -- requirements
Module: hls_macc_obf_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits (signed two's complement).
REQ-002 SHALL have parameter N_TERMS, default 4, number of product terms per operation (2..16).
REQ-003 SHALL have parameter THRESH, default 10, signed threshold compared against gain input g_in.
REQ-004 SHALL have parameter LOCK_W, default 3071, locking_key width; working key = locking_key[5:0].
REQ-005 SHALL have one clock; reset is synchronous and active-low (ports ap_clk, ap_rst_n).
REQ-006 ap_clk  in  1  rising-edge clock.
REQ-007 ap_rst_n  in  1  synchronous active-low reset.
REQ-008 ap_start  in  1  start request, level, sampled in IDLE.
REQ-009 ap_done, ap_idle, ap_ready  out  1 each  completion / idle / ready-for-new-start flags.
REQ-010 a_in, b_in  in  N_TERMS*DATA_W  packed operand vectors, term k at bits [k*DATA_W +: DATA_W].
REQ-011 c_in  in  DATA_W  accumulator seed; g_in  in  DATA_W  gain/branch-select input.
REQ-012 sat_en  in  1  saturation mode enable.
REQ-013 o_acc  out  DATA_W  result; o_acc_vld  out  1  result valid strobe.
REQ-014 locking_key  in  LOCK_W  obfuscation key; only bits [5:0] are functional.

Function
REQ-015 Every key-protected decision SHALL be computed as (raw_condition XOR working_key[i]); key 6'b000000 is the functionally correct key, and all requirements below are stated for it.
REQ-016 FSM states IDLE, LOAD, MAC, DONE, one-hot, 4 bits; reset state IDLE.
REQ-017 IDLE->LOAD when ap_start==1 (key bit 0); otherwise remain IDLE.
REQ-018 LOAD (1 cycle): register a_in, b_in, c_in, g_in, sat_en; acc <= c_in; term index k <= 0; sub_sel <= (g_in > THRESH) signed (key bit 2).
REQ-019 MAC: one term per cycle; acc <= acc + a[k]*b[k] if sub_sel==0, acc - a[k]*b[k] if sub_sel==1; product truncated to 2*DATA_W, accumulator 2*DATA_W+clog2(N_TERMS) bits, no overflow internally.
REQ-020 MAC->DONE after term k==N_TERMS-1 is accumulated; MAC lasts exactly N_TERMS cycles.
REQ-021 DONE (1 cycle): ap_done (key bit 1), ap_ready, o_acc_vld (key bit 4) high; DONE->IDLE unconditionally.
REQ-022 o_acc SHALL be registered in the MAC->DONE transition and held until the next DONE.
REQ-023 o_acc: if saturation active (sat_en XOR working_key[3]) clamp acc to [-2^(DATA_W-1), 2^(DATA_W-1)-1], else low DATA_W bits of acc (wrap).
REQ-024 ap_idle = IDLE & ~ap_start (key bit 5); ap_done/ap_ready/o_acc_vld low outside DONE.
REQ-025 Latency start-accepted to ap_done: N_TERMS+2 cycles; throughput one operation per N_TERMS+3 cycles.
REQ-026 ap_start held high through DONE SHALL start the next operation in the following IDLE cycle; inputs changed after LOAD SHALL not affect the result.

Reset
REQ-027 ap_rst_n==0 at a rising edge, in any state including mid-MAC, SHALL force IDLE, abandon the operation, clear acc, k, sub_sel, o_acc to 0; no o_acc_vld for the abandoned operation.
REQ-028 During reset ap_idle follows REQ-024 after the edge; ap_done, ap_ready, o_acc_vld SHALL be 0.

Structure
REQ-029 State encodings, key-bit index constants (KEY_START=0, KEY_DONE=1, KEY_SUB=2, KEY_SAT=3, KEY_VLD=4, KEY_IDLE=5) SHALL live in shared package hls_obf_pkg.
REQ-030 Saturating narrow function SHALL be one sub-module hls_obf_sat (combinational, parametrised IN_W/OUT_W).

Verification
REQ-031 Correct key, N_TERMS=4, a={1,2,3,4}, b={5,6,7,8}, c_in=10, g_in=0 -> o_acc=80, ap_done at cycle 6 after start.
REQ-032 Same, g_in=11 -> sub_sel=1, o_acc=10-70=-60; g_in=10 -> o_acc=80 (boundary not greater).
REQ-033 sat_en=1, a={2^30,2^30,0,0}, b={2,2,0,0}, c_in=0 -> o_acc=0x7FFFFFFF; sat_en=0 -> o_acc=0x00000000 (wrap).
REQ-034 ap_rst_n low for 1 cycle at MAC k=2 -> IDLE next cycle, no o_acc_vld, o_acc=0; next start computes correctly.
REQ-035 Key bit 2 set, vectors of REQ-031 -> o_acc=-60; key bit 4 set -> o_acc_vld high in every non-DONE cycle.
REQ-036 ap_start held high for 3 operations -> ap_done pulses every 7 cycles, results match model.
